// File: rtl/cbs_pkg.sv
// cbs_pkg: shared constants, state encoding and block sizing for cb_segmenter
package cbs_pkg;
  localparam int K_SMALL = 1056;
  localparam int K_LARGE = 6144;
  localparam int ADDR_W = 13;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    DATA    = 2'd2,
    PRESENT = 2'd3
  } cbs_state_e;
  function automatic logic [ADDR_W:0] cb_sizing(input logic [15:0] r, input int ks, input int kl);
    logic [15:0] k, t;
    k = r > 16'(ks) ? 16'(kl) : 16'(ks);
    t = r < k ? r : k;
    return {r > 16'(ks), ADDR_W'(k - t)};
  endfunction
endpackage

// File: rtl/byte_serializer.sv
// byte_serializer: loads one byte and emits it MSB first, one bit per cycle, requesting the next byte on its last bit
module byte_serializer (
  input  logic       clock,
  input  logic       aclr,
  input  logic       active,
  input  logic       more,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       bit_valid,
  output logic       bit_out
);
  logic [7:0] sh;
  logic [3:0] cnt;
  logic last;
  assign last = cnt == 4'd1;
  assign bit_valid = cnt != 4'd0;
  assign bit_out = sh[7];
  assign in_ready = active && (cnt == 4'd0 || (last && more));
  always_ff @(posedge clock or posedge aclr)
    if (aclr) begin
      sh <= '0;
      cnt <= '0;
    end else if (in_valid && in_ready) begin
      sh <= in_byte;
      cnt <= 4'd8;
    end else if (bit_valid) begin
      sh <= {sh[6:0], 1'b0};
      cnt <= cnt - 4'd1;
    end
endmodule

// File: rtl/cb_segmenter.sv
// cb_segmenter: splits a transport block byte stream into filler-padded 1056/6144-bit code blocks in a double-banked bit buffer
module cb_segmenter #(
  parameter int K_SMALL = cbs_pkg::K_SMALL,
  parameter int K_LARGE = cbs_pkg::K_LARGE,
  parameter int ADDR_W = cbs_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              tb_start,
  input  logic [15:0]       tb_len,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_bit,
  output logic              wr_bank,
  output logic              cbs_ready,
  input  logic              enc_ready,
  output logic              cb_size,
  output logic [ADDR_W-1:0] cb_filler,
  output logic              cb_bank,
  output logic              busy
);
  import cbs_pkg::*;
  cbs_state_e state, nstate;
  logic [15:0] r_q, sz_src, k_full;
  logic [cbs_pkg::ADDR_W:0] sz;
  logic [ADDR_W-1:0] fill_q, addr_q, k_last, sz_f;
  logic ksel_q, bank_q, sz_k, bit_valid, bit_out, blk_end, load, hs;
  assign sz_src = state == IDLE ? tb_len : r_q;
  assign sz = cb_sizing(sz_src, K_SMALL, K_LARGE);
  assign sz_k = sz[cbs_pkg::ADDR_W];
  assign sz_f = sz[ADDR_W-1:0];
  assign k_full = ksel_q ? 16'(K_LARGE) : 16'(K_SMALL);
  assign k_last = ADDR_W'(k_full - 16'd1);
  assign hs = state == PRESENT && enc_ready;
  assign load = (state == IDLE && tb_start && tb_len != '0) || (hs && r_q != '0);
  assign blk_end = state == DATA && bit_valid && addr_q == k_last;
  byte_serializer u_ser (
    .clock    (clock),
    .aclr     (aclr),
    .active   (state == DATA),
    .more     (addr_q != k_last),
    .in_byte  (in_byte),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bit_valid(bit_valid),
    .bit_out  (bit_out)
  );
  always_comb begin
    nstate = load ? (sz_f != '0 ? FILL : DATA) :
             hs ? IDLE :
             (state == FILL && addr_q == fill_q - ADDR_W'(1)) ? DATA :
             blk_end ? PRESENT : state;
    wr_en = state == FILL || (state == DATA && bit_valid);
    wr_bit = state == DATA && bit_valid && bit_out;
  end
  always_ff @(posedge clock or posedge aclr)
    if (aclr) begin
      state <= IDLE;
      r_q <= '0;
      ksel_q <= 1'b0;
      fill_q <= '0;
      addr_q <= '0;
      bank_q <= 1'b0;
    end else begin
      state <= nstate;
      r_q <= load ? sz_src : blk_end ? r_q - (k_full - 16'(fill_q)) : r_q;
      ksel_q <= load ? sz_k : ksel_q;
      fill_q <= load ? sz_f : fill_q;
      addr_q <= blk_end ? '0 : wr_en ? addr_q + ADDR_W'(1) : addr_q;
      bank_q <= bank_q ^ hs;
    end
  assign wr_addr = addr_q;
  assign wr_bank = bank_q;
  assign cbs_ready = state == PRESENT;
  assign cb_size = cbs_ready & ksel_q;
  assign cb_filler = cbs_ready ? fill_q : '0;
  assign cb_bank = cbs_ready & bank_q;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_cb_segmenter.sv
// tb_cb_segmenter: scoreboard bench for cb_segmenter with a block-level reference model
module tb_cb_segmenter;
  logic clock = 1'b0, aclr = 1'b1, tb_start = 1'b0, in_valid = 1'b0, enc_ready = 1'b1;
  logic [15:0] tb_len = '0;
  logic [7:0] in_byte = '0;
  logic in_ready, wr_en, wr_bit, wr_bank, cbs_ready, cb_size, cb_bank, busy;
  logic [12:0] wr_addr, cb_filler;
  int n_cmp = 0, n_err = 0;
  logic [14:0] exp_wr[$], exp_pr[$];
  logic [7:0] src_q[$];
  logic m_bank = 1'b0, gaps = 1'b0, rnd_enc = 1'b0, enc_fix = 1'b1, prev_cbs = 1'b0;
  logic [14:0] held;

  always #5 clock = ~clock;

  cb_segmenter dut (
    .clock    (clock),
    .aclr     (aclr),
    .tb_start (tb_start),
    .tb_len   (tb_len),
    .in_byte  (in_byte),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_bit   (wr_bit),
    .wr_bank  (wr_bank),
    .cbs_ready(cbs_ready),
    .enc_ready(enc_ready),
    .cb_size  (cb_size),
    .cb_filler(cb_filler),
    .cb_bank  (cb_bank),
    .busy     (busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic issue(input int len);
    int r, k, t, f;
    logic [7:0] b;
    logic dbits[$];
    r = len;
    for (int i = 0; i < len / 8; i++) begin
      b = 8'($urandom);
      src_q.push_back(b);
      for (int j = 7; j >= 0; j--) dbits.push_back(b[j]);
    end
    while (r > 0) begin
      k = r > 1056 ? 6144 : 1056;
      t = r < k ? r : k;
      f = k - t;
      for (int a = 0; a < k; a++) exp_wr.push_back({m_bank, 13'(a), a < f ? 1'b0 : dbits.pop_front()});
      exp_pr.push_back({k == 6144, 13'(f), m_bank});
      m_bank = ~m_bank;
      r -= t;
    end
    tb_start = 1'b1;
    tb_len = 16'(len);
    @(negedge clock);
    tb_start = 1'b0;
    chk("start_latency", wr_en | in_ready, 1);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_idle"}, busy, 0);
    chk({nm, "_drained"}, exp_wr.size() + exp_pr.size(), 0);
  endtask

  initial forever begin
    @(negedge clock);
    enc_ready = rnd_enc ? 1'($urandom_range(0, 1)) : enc_fix;
    in_valid = src_q.size() != 0 && (!gaps || $urandom_range(0, 3) != 0);
    in_byte = src_q.size() != 0 ? src_q[0] : 8'h00;
    if (in_valid && in_ready) void'(src_q.pop_front());
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (aclr) prev_cbs = 1'b0;
    else begin
      if (wr_en) begin
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL wr_extra: got write bank %0d addr %0d bit %0d, expected none", wr_bank, wr_addr, wr_bit);
        end else chk("wr_bank_addr_bit", {wr_bank, wr_addr, wr_bit}, exp_wr.pop_front());
      end
      if (prev_cbs) chk("cbs_handshake", cbs_ready, !enc_ready);
      if (cbs_ready && !prev_cbs) begin
        if (exp_pr.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL present_extra: got size %0d filler %0d bank %0d, expected none", cb_size, cb_filler, cb_bank);
        end else begin
          held = exp_pr.pop_front();
          chk("present_fields", {cb_size, cb_filler, cb_bank}, held);
        end
      end else if (cbs_ready) chk("present_stable", {cb_size, cb_filler, cb_bank}, held);
      if (cbs_ready) chk("present_quiet", {wr_en, in_ready}, 0);
      prev_cbs = cbs_ready;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge clock);
    chk("rst_outs_a", {wr_en, wr_addr, wr_bit, wr_bank, cbs_ready}, 0);
    chk("rst_outs_b", {cb_size, cb_filler, cb_bank, busy, in_ready}, 0);
    aclr = 1'b0;
    @(negedge clock);
    tb_start = 1'b1;
    tb_len = '0;
    @(negedge clock);
    tb_start = 1'b0;
    chk("len0_ignored", busy, 0);
    @(negedge clock);
    issue(1056);
    n = 1;
    while (!cbs_ready && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk("rate_1056", n, 1058);
    wait_idle("t1056");
    issue(2000);
    wait_idle("t2000");
    issue(7200);
    wait_idle("t7200");
    enc_fix = 1'b0;
    issue(64);
    n = 0;
    while (!cbs_ready && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk("hold_reach", cbs_ready, 1);
    repeat (50) @(negedge clock);
    chk("hold_waiting", {busy, cbs_ready}, 2'b11);
    enc_fix = 1'b1;
    wait_idle("hold");
    gaps = 1'b1;
    issue(1600);
    n = 0;
    while (wr_addr < 13'd5000 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    tb_start = 1'b1;
    tb_len = 16'd800;
    @(negedge clock);
    tb_start = 1'b0;
    chk("stray_start_busy", busy, 1);
    wait_idle("gaps");
    rnd_enc = 1'b1;
    for (int i = 0; i < 2; i++) begin
      issue(8 * int'($urandom_range(1, 1100)));
      wait_idle("rand");
    end
    rnd_enc = 1'b0;
    gaps = 1'b0;
    @(negedge clock);
    issue(3000);
    n = 0;
    while (wr_addr != 13'd3400 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    aclr = 1'b1;
    #1;
    chk("aclr_outs_a", {wr_en, wr_addr, wr_bit, cbs_ready}, 0);
    chk("aclr_outs_b", {cb_size, cb_filler, cb_bank, busy, in_ready}, 0);
    chk("aclr_bank", wr_bank, 0);
    exp_wr.delete();
    exp_pr.delete();
    src_q.delete();
    m_bank = 1'b0;
    @(negedge clock);
    aclr = 1'b0;
    issue(800);
    wait_idle("post_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
